// File: rtl/conv_mac_feeder_if.sv
// conv_mac_feeder_if: control, SRAM-read, MAC-lane and ofmap-write signals of the conv MAC feeder.
interface conv_mac_feeder_if #(
    parameter int IFM_AW = 6,
    parameter int WGT_AW = 4,
    parameter int OFM_AW = 6
);
    logic                     start;
    logic signed [7:0]        bias;
    logic                     busy;
    logic                     done;
    logic        [IFM_AW-1:0] ifm_addr;
    logic signed [7:0]        ifm_rdata;
    logic        [WGT_AW-1:0] wgt_addr;
    logic signed [7:0]        wgt_rdata;
    logic                     mac_rstn;
    logic                     mac_enable;
    logic                     mac_only_add;
    logic signed [7:0]        mac_din_a;
    logic signed [7:0]        mac_din_b;
    logic signed [7:0]        mac_dout;
    logic                     ofm_valid;
    logic                     ofm_ready;
    logic        [OFM_AW-1:0] ofm_addr;
    logic signed [7:0]        ofm_data;
    modport master (
        input  start, bias, ifm_rdata, wgt_rdata, mac_dout, ofm_ready,
        output busy, done, ifm_addr, wgt_addr, mac_rstn, mac_enable, mac_only_add,
               mac_din_a, mac_din_b, ofm_valid, ofm_addr, ofm_data
    );
    modport slave (
        output start, bias, ifm_rdata, wgt_rdata, mac_dout, ofm_ready,
        input  busy, done, ifm_addr, wgt_addr, mac_rstn, mac_enable, mac_only_add,
               mac_din_a, mac_din_b, ofm_valid, ofm_addr, ofm_data
    );
endinterface

// File: rtl/conv_mac_feeder.sv
// conv_mac_feeder: drives one signed MAC lane through a stride-1 valid 2-D convolution,
// per output pixel: clear, bias, K*K taps, then hand the quantized result to the ofmap buffer.
module conv_mac_feeder #(
    parameter int K      = 3,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int IFM_AW = 6,
    parameter int WGT_AW = 4,
    parameter int OFM_AW = 6
) (
    input logic clk,
    input logic rstn,
    conv_mac_feeder_if.master bus
);
    localparam int OW = IMG_W - K + 1;
    localparam int OH = IMG_H - K + 1;
    localparam int CW = 8;
    typedef enum logic [2:0] {IDLE, CLEAR, BIAS, MAC, OUT, DONE} state_t;
    state_t        r_state;
    logic [CW-1:0] r_ox, r_oy, r_kx, r_ky, r_t;
    logic          w_last_tap, w_kx_wrap, w_ox_wrap, w_last_px, w_issue;
    assign w_last_tap = r_t == CW'(K * K - 1);
    assign w_kx_wrap  = r_kx == CW'(K - 1);
    assign w_ox_wrap  = r_ox == CW'(OW - 1);
    assign w_last_px  = w_ox_wrap && r_oy == CW'(OH - 1);
    // r_kx/r_ky run one tap ahead of r_t so the synchronous SRAMs return tap t during MAC tap t
    assign w_issue    = r_state == BIAS || (r_state == MAC && !w_last_tap);
    assign bus.busy         = r_state != IDLE && r_state != DONE;
    assign bus.done         = r_state == DONE;
    assign bus.mac_rstn     = rstn && r_state != CLEAR;
    assign bus.mac_enable   = r_state == BIAS || r_state == MAC;
    assign bus.mac_only_add = r_state == BIAS;
    assign bus.mac_din_a    = r_state == MAC ? bus.ifm_rdata : r_state == BIAS ? bus.bias : 8'sd0;
    assign bus.mac_din_b    = r_state == MAC ? bus.wgt_rdata : 8'sd0;
    assign bus.ifm_addr     = w_issue ? IFM_AW'((32'(r_oy) + 32'(r_ky)) * IMG_W + 32'(r_ox) + 32'(r_kx)) : '0;
    assign bus.wgt_addr     = w_issue ? WGT_AW'(32'(r_ky) * K + 32'(r_kx)) : '0;
    assign bus.ofm_valid    = r_state == OUT;
    assign bus.ofm_addr     = r_state == OUT ? OFM_AW'(32'(r_oy) * OW + 32'(r_ox)) : '0;
    assign bus.ofm_data     = r_state == OUT ? bus.mac_dout : 8'sd0;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_ox    <= '0;
            r_oy    <= '0;
            r_kx    <= '0;
            r_ky    <= '0;
            r_t     <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.start) begin
                    r_state <= CLEAR;
                    r_ox    <= '0;
                    r_oy    <= '0;
                end
                CLEAR: begin
                    r_state <= BIAS;
                    r_kx    <= '0;
                    r_ky    <= '0;
                end
                BIAS, MAC: begin
                    r_kx    <= w_kx_wrap ? '0 : r_kx + 1'b1;
                    r_ky    <= w_kx_wrap ? r_ky + 1'b1 : r_ky;
                    r_t     <= r_state == BIAS ? '0 : r_t + 1'b1;
                    r_state <= (r_state == MAC && w_last_tap) ? OUT : MAC;
                end
                OUT: if (bus.ofm_ready) begin
                    r_state <= w_last_px ? DONE : CLEAR;
                    r_ox    <= w_ox_wrap ? '0 : r_ox + 1'b1;
                    r_oy    <= w_ox_wrap ? r_oy + 1'b1 : r_oy;
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_mac_feeder.sv
// tb_conv_mac_feeder: 4x4 image, K=3 bench with SRAM and MAC-lane models; results are
// compared against a direct convolution computed from the memory contents.
module tb_conv_mac_feeder;
    localparam int K = 3, W = 4, H = 4, OW = W - K + 1, OH = H - K + 1;
    localparam int NPX = OW * OH, PXC = K * K + 3, FRAME = NPX * PXC + 1;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;
    conv_mac_feeder_if #(.IFM_AW(6), .WGT_AW(4), .OFM_AW(6)) bus ();
    conv_mac_feeder #(.K(K), .IMG_W(W), .IMG_H(H), .IFM_AW(6), .WGT_AW(4), .OFM_AW(6)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );
    int errors = 0, checks = 0;
    logic signed [7:0] ifm_mem [64];
    logic signed [7:0] wgt_mem [16];
    int acc = 0;
    int q_addr [$];
    logic [7:0] q_data [$];

    function automatic logic [7:0] sat8(int v);
        return v > 127 ? 8'h7F : v < -128 ? 8'h80 : 8'(v);
    endfunction

    // stand-in MAC lane: bias enters as din_a<<8, products accumulate, output is acc/256 saturated
    always @(posedge clk) begin
        bus.ifm_rdata <= ifm_mem[bus.ifm_addr];
        bus.wgt_rdata <= wgt_mem[bus.wgt_addr];
        if (!bus.mac_rstn) acc <= 0;
        else if (bus.mac_enable)
            acc <= acc + (bus.mac_only_add ? int'(bus.mac_din_a) * 256 : int'(bus.mac_din_a) * int'(bus.mac_din_b));
    end
    assign bus.mac_dout = sat8(acc >>> 8);

    always @(negedge clk)
        if (rstn && bus.ofm_valid && bus.ofm_ready) begin
            q_addr.push_back(int'(bus.ofm_addr));
            q_data.push_back(bus.ofm_data);
        end

    function automatic logic [7:0] ref_px(int ox, int oy, logic signed [7:0] b);
        int s = int'(b) * 256;
        for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
                s += int'(ifm_mem[(oy + ky) * W + ox + kx]) * int'(wgt_mem[ky * K + kx]);
        return sat8(s >>> 8);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_const(input int a, input int b);
        for (int i = 0; i < 64; i++) ifm_mem[i] = 8'(a);
        for (int i = 0; i < 16; i++) wgt_mem[i] = 8'(b);
    endtask

    task automatic fill_rand;
        for (int i = 0; i < 64; i++) ifm_mem[i] = 8'($urandom);
        for (int i = 0; i < 16; i++) wgt_mem[i] = 8'($urandom);
        bus.bias = 8'($urandom);
    endtask

    // starts a frame and returns the cycle index of done (acceptance cycle = 0), -1 on timeout
    task automatic run_frame(input bit hold, input bit rnd, output int cyc);
        q_addr.delete();
        q_data.delete();
        bus.start = 1'b1;
        tick();
        if (!hold) bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 3000) begin
            if (rnd) bus.ofm_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end
        bus.ofm_ready = 1'b1;
        if (!bus.done) cyc = -1;
    endtask

    task automatic test_reset;
        fill_const(0, 0);
        bus.start = 1'b0;
        bus.bias = 8'sd0;
        bus.ofm_ready = 1'b1;
        rstn = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus.mac_rstn !== 1'b0) begin errors++; $display("FAIL reset_mac_rstn: got %b expected 0", bus.mac_rstn); end
        rstn = 1'b1;
        tick();
        checks++;
        if ({bus.busy, bus.done, bus.mac_enable, bus.mac_only_add, bus.ofm_valid, bus.ifm_addr, bus.wgt_addr,
             bus.mac_din_a, bus.mac_din_b, bus.ofm_addr, bus.ofm_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b en=%b add=%b valid=%b ifm=%0d wgt=%0d a=%0h b=%0h oa=%0d od=%0h expected all 0",
                     bus.busy, bus.done, bus.mac_enable, bus.mac_only_add, bus.ofm_valid, bus.ifm_addr, bus.wgt_addr,
                     bus.mac_din_a, bus.mac_din_b, bus.ofm_addr, bus.ofm_data);
        end
        checks++;
        if (bus.mac_rstn !== 1'b1) begin errors++; $display("FAIL reset_mac_rstn_idle: got %b expected 1", bus.mac_rstn); end
    endtask

    task automatic test_const_frames;
        int t_ifm [3] = '{16, 16, 127};
        int t_wgt [3] = '{16, -16, 127};
        int t_bias [3] = '{5, 0, 0};
        logic [7:0] t_exp [3] = '{8'h0E, 8'hF7, 8'h7F};
        int cyc;
        for (int i = 0; i < 3; i++) begin
            fill_const(t_ifm[i], t_wgt[i]);
            bus.bias = 8'(t_bias[i]);
            run_frame(1'b0, 1'b0, cyc);
            checks++;
            if (cyc !== FRAME) begin errors++; $display("FAIL const%0d_done_cycle: got %0d expected %0d", i, cyc, FRAME); end
            checks++;
            if (q_data.size() !== NPX) begin errors++; $display("FAIL const%0d_writes: got %0d expected %0d", i, q_data.size(), NPX); end
            for (int p = 0; p < q_data.size() && p < NPX; p++) begin
                checks++;
                if (q_addr[p] !== p || q_data[p] !== t_exp[i]) begin
                    errors++;
                    $display("FAIL const%0d_px%0d: got addr=%0d data=%0h expected addr=%0d data=%0h", i, p, q_addr[p], q_data[p], p, t_exp[i]);
                end
            end
            tick();
        end
    endtask

    task automatic test_random;
        int cyc;
        for (int it = 0; it < 3; it++) begin
            fill_rand();
            run_frame(1'b0, 1'b1, cyc);
            checks++;
            if (cyc < 0) begin errors++; $display("FAIL random%0d_timeout: got no done expected done", it); end
            checks++;
            if (q_data.size() !== NPX) begin errors++; $display("FAIL random%0d_writes: got %0d expected %0d", it, q_data.size(), NPX); end
            for (int p = 0; p < q_data.size() && p < NPX; p++) begin
                checks++;
                if (q_addr[p] !== p || q_data[p] !== ref_px(p % OW, p / OW, bus.bias)) begin
                    errors++;
                    $display("FAIL random%0d_px%0d: got addr=%0d data=%0h expected addr=%0d data=%0h", it, p, q_addr[p], q_data[p], p, ref_px(p % OW, p / OW, bus.bias));
                end
            end
            tick();
        end
    endtask

    task automatic test_addr_trace;
        int p, ph, ox, oy, j;
        fill_rand();
        bus.ofm_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < FRAME; cyc++) begin
            p = (cyc - 1) / PXC;
            ph = (cyc - 1) % PXC;
            ox = p % OW;
            oy = p / OW;
            checks++;
            if (bus.mac_enable !== (ph >= 1 && ph <= K * K + 1)) begin
                errors++; $display("FAIL trace_enable c%0d: got %b expected %b", cyc, bus.mac_enable, ph >= 1 && ph <= K * K + 1);
            end
            if (ph == 0) begin
                checks++;
                if (bus.mac_rstn !== 1'b0) begin errors++; $display("FAIL trace_clear c%0d: got mac_rstn=%b expected 0", cyc, bus.mac_rstn); end
            end
            if (ph == 1) begin
                checks++;
                if (bus.mac_only_add !== 1'b1 || bus.mac_din_a !== bus.bias || bus.mac_din_b !== 8'sd0) begin
                    errors++; $display("FAIL trace_bias c%0d: got add=%b a=%0h b=%0h expected add=1 a=%0h b=0", cyc, bus.mac_only_add, bus.mac_din_a, bus.mac_din_b, bus.bias);
                end
            end
            if (ph >= 1 && ph <= K * K && (p == 0 || p == NPX - 1)) begin
                j = ph - 1;
                checks++;
                if (int'(bus.ifm_addr) !== (oy + j / K) * W + ox + j % K || int'(bus.wgt_addr) !== j) begin
                    errors++; $display("FAIL trace_addr p%0d t%0d: got ifm=%0d wgt=%0d expected ifm=%0d wgt=%0d", p, j, bus.ifm_addr, bus.wgt_addr, (oy + j / K) * W + ox + j % K, j);
                end
            end
            if (ph >= 2 && ph <= K * K + 1) begin
                j = ph - 2;
                checks++;
                if (bus.mac_only_add !== 1'b0 || bus.mac_din_a !== ifm_mem[(oy + j / K) * W + ox + j % K] || bus.mac_din_b !== wgt_mem[j]) begin
                    errors++; $display("FAIL trace_operand p%0d t%0d: got a=%0h b=%0h expected a=%0h b=%0h", p, j, bus.mac_din_a, bus.mac_din_b, ifm_mem[(oy + j / K) * W + ox + j % K], wgt_mem[j]);
                end
            end
            if (ph == PXC - 1) begin
                checks++;
                if (bus.ofm_valid !== 1'b1 || bus.ofm_data !== ref_px(ox, oy, bus.bias)) begin
                    errors++; $display("FAIL trace_out p%0d: got valid=%b data=%0h expected valid=1 data=%0h", p, bus.ofm_valid, bus.ofm_data, ref_px(ox, oy, bus.bias));
                end
            end
            tick();
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL trace_done: got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy); end
        tick();
    endtask

    task automatic test_stall;
        int n = 0;
        logic [5:0] h_addr;
        logic [7:0] h_data;
        fill_rand();
        q_addr.delete();
        q_data.delete();
        bus.ofm_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        while (!bus.ofm_valid && n < 50) begin tick(); n++; end
        h_addr = bus.ofm_addr;
        h_data = bus.ofm_data;
        checks++;
        if (bus.ofm_valid !== 1'b1 || h_addr !== 6'd0 || h_data !== ref_px(0, 0, bus.bias)) begin
            errors++; $display("FAIL stall_first_out: got valid=%b addr=%0d data=%0h expected valid=1 addr=0 data=%0h", bus.ofm_valid, h_addr, h_data, ref_px(0, 0, bus.bias));
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.ofm_valid !== 1'b1 || bus.ofm_addr !== h_addr || bus.ofm_data !== h_data || bus.mac_enable !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d: got valid=%b addr=%0d data=%0h en=%b expected valid=1 addr=%0d data=%0h en=0", i, bus.ofm_valid, bus.ofm_addr, bus.ofm_data, bus.mac_enable, h_addr, h_data);
            end
            if (i < 4) tick();
        end
        bus.ofm_ready = 1'b1;
        tick();
        checks++;
        if (bus.mac_rstn !== 1'b0 || bus.ofm_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: got mac_rstn=%b valid=%b expected mac_rstn=0 valid=0", bus.mac_rstn, bus.ofm_valid);
        end
        n = 0;
        while (!bus.done && n < 200) begin tick(); n++; end
        checks++;
        if (q_data.size() !== NPX) begin errors++; $display("FAIL stall_writes: got %0d expected %0d", q_data.size(), NPX); end
        for (int p = 0; p < q_data.size() && p < NPX; p++) begin
            checks++;
            if (q_addr[p] !== p || q_data[p] !== ref_px(p % OW, p / OW, bus.bias)) begin
                errors++; $display("FAIL stall_px%0d: got addr=%0d data=%0h expected addr=%0d data=%0h", p, q_addr[p], q_data[p], p, ref_px(p % OW, p / OW, bus.bias));
            end
        end
        tick();
    endtask

    task automatic test_mid_reset;
        int cyc;
        bit seen = 1'b0;
        fill_rand();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 2 * PXC + 3; c++) tick();
        checks++;
        if (bus.mac_enable !== 1'b1 || bus.mac_only_add !== 1'b0) begin
            errors++; $display("FAIL midrst_in_mac: got en=%b add=%b expected en=1 add=0", bus.mac_enable, bus.mac_only_add);
        end
        rstn = 1'b0;
        tick();
        checks++;
        if ({bus.busy, bus.ofm_valid, bus.mac_enable, bus.mac_rstn, bus.ifm_addr} !== '0) begin
            errors++; $display("FAIL midrst_outputs: got busy=%b valid=%b en=%b mac_rstn=%b ifm=%0d expected all 0", bus.busy, bus.ofm_valid, bus.mac_enable, bus.mac_rstn, bus.ifm_addr);
        end
        rstn = 1'b1;
        repeat (60) begin tick(); if (bus.done || bus.busy) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL midrst_abandon: got done/busy after reset expected none"); end
        run_frame(1'b0, 1'b0, cyc);
        checks++;
        if (cyc !== FRAME) begin errors++; $display("FAIL midrst_frame_cycle: got %0d expected %0d", cyc, FRAME); end
        checks++;
        if (q_data.size() !== NPX) begin errors++; $display("FAIL midrst_writes: got %0d expected %0d", q_data.size(), NPX); end
        for (int p = 0; p < q_data.size() && p < NPX; p++) begin
            checks++;
            if (q_addr[p] !== p || q_data[p] !== ref_px(p % OW, p / OW, bus.bias)) begin
                errors++; $display("FAIL midrst_px%0d: got addr=%0d data=%0h expected addr=%0d data=%0h", p, q_addr[p], q_data[p], p, ref_px(p % OW, p / OW, bus.bias));
            end
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int cyc;
        fill_rand();
        run_frame(1'b1, 1'b0, cyc);
        checks++;
        if (cyc !== FRAME) begin errors++; $display("FAIL b2b_held_start_cycle: got %0d expected %0d", cyc, FRAME); end
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_start_in_done: got busy=%b expected 0", bus.busy); end
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy=%b expected 0", bus.busy); end
        fill_rand();
        run_frame(1'b0, 1'b0, cyc);
        checks++;
        if (cyc !== FRAME || q_data.size() !== NPX) begin
            errors++; $display("FAIL b2b_second_frame: got cycle=%0d writes=%0d expected cycle=%0d writes=%0d", cyc, q_data.size(), FRAME, NPX);
        end
        for (int p = 0; p < q_data.size() && p < NPX; p++) begin
            checks++;
            if (q_addr[p] !== p || q_data[p] !== ref_px(p % OW, p / OW, bus.bias)) begin
                errors++; $display("FAIL b2b_px%0d: got addr=%0d data=%0h expected addr=%0d data=%0h", p, q_addr[p], q_data[p], p, ref_px(p % OW, p / OW, bus.bias));
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_const_frames();
        test_addr_trace();
        test_random();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected completion");
        $fatal(1);
    end
endmodule
